// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampled UART core.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;

  // word_len encoding: number of data bits minus 5
  localparam logic [1:0] WLEN_5 = 2'd0;
  localparam logic [1:0] WLEN_6 = 2'd1;
  localparam logic [1:0] WLEN_7 = 2'd2;
  localparam logic [1:0] WLEN_8 = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_tx_state_t;

  // Parity over the active data bits; inverted for odd parity.
  function automatic logic uart_parity(logic [7:0] data, logic [1:0] wlen, logic even);
    logic [7:0] mask;
    logic       p;
    mask = 8'hFF >> (WLEN_8 - wlen);
    p    = ^(data & mask);
    return even ? p : ~p;
  endfunction

endpackage

// File: rtl/uart_shift_reg_pl_so.sv
// 8-bit parallel-load, shift-right register exposing only its LSB.
module uart_shift_reg_pl_so (
  input  logic       clk,
  input  logic       rst,
  input  logic       srst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] d,
  output logic       q0
);

  logic [7:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= 8'h00;
    end else if (srst) begin
      r_q <= 8'h00;
    end else if (load) begin
      r_q <= d;
    end else if (shift) begin
      r_q <= {1'b0, r_q[7:1]};
    end
  end

  assign q0 = r_q[0];

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, 5-8 data bits LSB-first, optional parity, 1-2 stop bits.
module uart_tx_serializer
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       srst,
  input  logic       brc,
  input  logic [7:0] d,
  input  logic       d_valid,
  output logic       d_ready,
  input  logic [1:0] word_len,
  input  logic       parity_en,
  input  logic       parity_even,
  input  logic       stop2,
  output logic       sout,
  output logic       busy
);

  localparam logic [3:0] TickLast = 4'(UART_OVERSAMPLE - 1);

  uart_tx_state_t r_state;
  logic [3:0]     r_tick;
  logic [2:0]     r_idx;
  logic [1:0]     r_wlen;
  logic           r_par_en;
  logic           r_par_bit;
  logic           r_stop2;
  logic           r_stop_cnt;
  logic           r_sout;

  logic w_accept;
  logic w_bit_end;
  logic w_shift;
  logic w_last_data;
  logic w_q0;

  assign w_accept    = (r_state == StIdle) && d_valid;
  assign w_bit_end   = brc && (r_state != StIdle) && (r_tick == TickLast);
  assign w_shift     = w_bit_end && ((r_state == StStart) || (r_state == StData));
  assign w_last_data = (r_idx == ({1'b0, r_wlen} + 3'd4));

  // The register shifts one bit ahead of sout so q0 always holds the next data bit,
  // letting sout be loaded from a flop on the same edge that ends the current bit.
  uart_shift_reg_pl_so u_shift (
    .clk  (clk),
    .rst  (rst),
    .srst (srst),
    .load (w_accept),
    .shift(w_shift),
    .d    (d),
    .q0   (w_q0)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_tick     <= 4'd0;
      r_idx      <= 3'd0;
      r_wlen     <= 2'd0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_sout     <= 1'b1;
    end else if (srst) begin
      r_state    <= StIdle;
      r_tick     <= 4'd0;
      r_idx      <= 3'd0;
      r_wlen     <= 2'd0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_cnt <= 1'b0;
      r_sout     <= 1'b1;
    end else if (r_state == StIdle) begin
      if (d_valid) begin
        r_state    <= StStart;
        r_tick     <= 4'd0;
        r_idx      <= 3'd0;
        r_wlen     <= word_len;
        r_par_en   <= parity_en;
        r_par_bit  <= uart_parity(d, word_len, parity_even);
        r_stop2    <= stop2;
        r_stop_cnt <= 1'b0;
        r_sout     <= 1'b0;
      end
    end else if (brc) begin
      r_tick <= r_tick + 4'd1;
      if (r_tick == TickLast) begin
        case (r_state)
          StStart: begin
            r_state <= StData;
            r_idx   <= 3'd0;
            r_sout  <= w_q0;
          end
          StData: begin
            if (!w_last_data) begin
              r_idx  <= r_idx + 3'd1;
              r_sout <= w_q0;
            end else if (r_par_en) begin
              r_state <= StParity;
              r_sout  <= r_par_bit;
            end else begin
              r_state    <= StStop;
              r_stop_cnt <= 1'b0;
              r_sout     <= 1'b1;
            end
          end
          StParity: begin
            r_state    <= StStop;
            r_stop_cnt <= 1'b0;
            r_sout     <= 1'b1;
          end
          StStop: begin
            if (r_stop2 && !r_stop_cnt) begin
              r_stop_cnt <= 1'b1;
            end else begin
              r_state <= StIdle;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign sout    = r_sout;
  assign d_ready = (r_state == StIdle);
  assign busy    = (r_state != StIdle);

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: frame table plus back-to-back and abort sequences.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  logic       clk;
  logic       rst;
  logic       srst;
  logic       brc;
  logic [7:0] d;
  logic       d_valid;
  logic       d_ready;
  logic [1:0] word_len;
  logic       parity_en;
  logic       parity_even;
  logic       stop2;
  logic       sout;
  logic       busy;

  int n_err = 0;
  int n_chk = 0;
  int brc_div = 1;
  bit brc_stall = 0;
  int bcnt = 0;

  // Frame bit i (0 = start) is frame[i]; len is total bit count.
  typedef struct {
    string      name;
    logic [7:0] d;
    logic [1:0] wl;
    logic       pe;
    logic       pev;
    logic       s2;
    int         div;
    int         stall_at;
    logic [11:0] frame;
    int         len;
  } vec_t;

  vec_t vecs[8];

  uart_tx_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .srst       (srst),
    .brc        (brc),
    .d          (d),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .word_len   (word_len),
    .parity_en  (parity_en),
    .parity_even(parity_even),
    .stop2      (stop2),
    .sout       (sout),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // brc changes on the falling edge so it is stable around every rising edge.
  initial begin
    brc = 1'b0;
    forever begin
      @(negedge clk);
      bcnt++;
      brc = !brc_stall && ((bcnt % brc_div) == 0);
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ticks(input string name, input int n);
    int t;
    int cyc;
    t   = 0;
    cyc = 0;
    while (t < n && cyc < n * brc_div + 50) begin
      @(posedge clk);
      #1;
      cyc++;
      if (brc) t++;
    end
    chkn({name, " ticks"}, t, n);
  endtask

  // Called one step after the accept edge; returns one step after the final stop-bit edge.
  task automatic run_frame(input string name, input logic [11:0] frame, input int len,
                           input int div, input int stall_at);
    int   t;
    int   cyc;
    int   c16;
    int   c32;
    bit   stalled;
    logic held;
    t       = 0;
    cyc     = 0;
    c16     = 0;
    c32     = 0;
    stalled = 0;
    chk1({name, " sout_at_accept"}, sout, frame[0]);
    chk1({name, " busy_at_accept"}, busy, 1'b1);
    chk1({name, " ready_at_accept"}, d_ready, 1'b0);
    while (t < UART_OVERSAMPLE * len && cyc < UART_OVERSAMPLE * len * div + 250) begin
      @(posedge clk);
      #1;
      cyc++;
      if (brc) begin
        t++;
        if (t == 16) c16 = cyc;
        if (t == 32) c32 = cyc;
      end
      if (t < UART_OVERSAMPLE * len) begin
        chk1({name, " sout"}, sout, frame[t / UART_OVERSAMPLE]);
        chk1({name, " ready_busy"}, d_ready, 1'b0);
      end
      if (stall_at != 0 && t == stall_at && !stalled) begin
        stalled   = 1;
        held      = sout;
        brc_stall = 1;
        repeat (100) begin
          @(posedge clk);
          #1;
          cyc++;
          chk1({name, " stall_hold"}, sout, held);
        end
        brc_stall = 0;
      end
    end
    chkn({name, " frame_ticks"}, t, UART_OVERSAMPLE * len);
    chk1({name, " ready_end"}, d_ready, 1'b1);
    chk1({name, " busy_end"}, busy, 1'b0);
    chk1({name, " sout_idle"}, sout, 1'b1);
    if (div == 1) chkn({name, " frame_cycles"}, cyc, UART_OVERSAMPLE * len);
    if (div > 1 && stall_at == 0) chkn({name, " bit_cycles"}, c32 - c16, UART_OVERSAMPLE * div);
  endtask

  task automatic send(input vec_t v);
    brc_div     = v.div;
    d           = v.d;
    word_len    = v.wl;
    parity_en   = v.pe;
    parity_even = v.pev;
    stop2       = v.s2;
    d_valid     = 1'b1;
    chk1({v.name, " ready_before"}, d_ready, 1'b1);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    run_frame(v.name, v.frame, v.len, v.div, v.stall_at);
  endtask

  initial begin
    rst         = 1'b1;
    srst        = 1'b0;
    d           = 8'h00;
    d_valid     = 1'b0;
    word_len    = WLEN_8;
    parity_en   = 1'b0;
    parity_even = 1'b0;
    stop2       = 1'b0;

    vecs[0] = '{"8N1_A5",    8'hA5, WLEN_8, 1'b0, 1'b0, 1'b0, 1, 0,  12'h34A, 10};
    vecs[1] = '{"7E1_C1",    8'hC1, WLEN_7, 1'b1, 1'b1, 1'b0, 1, 0,  12'h282, 10};
    vecs[2] = '{"5O2_FF",    8'hFF, WLEN_5, 1'b1, 1'b0, 1'b1, 1, 0,  12'h1BE, 9};
    vecs[3] = '{"6O1_ED",    8'hED, WLEN_6, 1'b1, 1'b0, 1'b0, 1, 0,  12'h1DA, 9};
    vecs[4] = '{"8E2_00",    8'h00, WLEN_8, 1'b1, 1'b1, 1'b1, 1, 0,  12'hC00, 12};
    vecs[5] = '{"8O1_3C",    8'h3C, WLEN_8, 1'b1, 1'b0, 1'b0, 1, 0,  12'h678, 11};
    vecs[6] = '{"8N1_div4",  8'h5A, WLEN_8, 1'b0, 1'b0, 1'b0, 4, 0,  12'h2B4, 10};
    vecs[7] = '{"8N1_stall", 8'h5A, WLEN_8, 1'b0, 1'b0, 1'b0, 4, 56, 12'h2B4, 10};

    repeat (3) @(posedge clk);
    #1;
    chk1("reset sout", sout, 1'b1);
    chk1("reset ready", d_ready, 1'b1);
    chk1("reset busy", busy, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      send(vecs[i]);
      @(posedge clk);
      #1;
    end

    // Back-to-back with d_valid held; stop2 flips during the first frame.
    brc_div   = 1;
    d         = 8'h00;
    word_len  = WLEN_8;
    parity_en = 1'b0;
    stop2     = 1'b0;
    d_valid   = 1'b1;
    @(posedge clk);
    #1;
    d     = 8'hFF;
    stop2 = 1'b1;
    run_frame("b2b_first", 12'h200, 10, 1, 0);
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    run_frame("b2b_second", 12'h7FE, 11, 1, 0);
    @(posedge clk);
    #1;

    // Asynchronous abort at tick 40.
    d       = 8'h00;
    stop2   = 1'b0;
    d_valid = 1'b1;
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    wait_ticks("rst_abort", 40);
    chk1("rst_abort sout_before", sout, 1'b0);
    rst = 1'b1;
    #1;
    chk1("rst_abort sout_async", sout, 1'b1);
    chk1("rst_abort ready_async", d_ready, 1'b1);
    chk1("rst_abort busy_async", busy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(vecs[0]);
    @(posedge clk);
    #1;

    // Synchronous abort at tick 40, then srst beating a simultaneous accept.
    brc_div = 1;
    d       = 8'h00;
    word_len = WLEN_8;
    parity_en = 1'b0;
    stop2   = 1'b0;
    d_valid = 1'b1;
    @(posedge clk);
    #1;
    d_valid = 1'b0;
    wait_ticks("srst_abort", 40);
    srst = 1'b1;
    #1;
    chk1("srst_abort sout_before_edge", sout, 1'b0);
    @(posedge clk);
    #1;
    chk1("srst_abort sout", sout, 1'b1);
    chk1("srst_abort ready", d_ready, 1'b1);
    chk1("srst_abort busy", busy, 1'b0);
    d_valid = 1'b1;
    @(posedge clk);
    #1;
    chk1("srst_priority busy", busy, 1'b0);
    chk1("srst_priority sout", sout, 1'b1);
    srst    = 1'b0;
    d_valid = 1'b0;
    @(posedge clk);
    #1;
    send(vecs[2]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
